lfsr_tick_monitor: RTL
======================

// Module: lfsr_tick_monitor
// PURPOSE
//  Receive-side checker for the periodic single-cycle ticks from the LFSR timers (e.g. the 5 ms tick).
//  Measures the interval between consecutive ticks and flags each one as good, early or late.
//  Reports lock status and keeps an error count.
//  Sits in the clk domain, next to the tick consumer; used for bring-up and as a run-time health monitor.
// PARAMETERS
//  PERIOD   250  nominal tick interval, clk cycles (tick-cycle to tick-cycle)
//  TOL      2    accepted deviation, cycles; window = [PERIOD-TOL, PERIOD+TOL]; TOL < PERIOD
//  LOCK_N   4    consecutive good intervals required to assert locked (1..15)
//  CW       9    interval counter width; must hold PERIOD+TOL+1
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous reset, active-high
//  en         in   1  monitor enable; low forces IDLE
//  tick_in    in   1  tick from timer; event = rising edge (high now, low last cycle)
//  good       out  1  1-cycle pulse: interval inside window
//  early_err  out  1  1-cycle pulse: tick arrived before PERIOD-TOL
//  late_err   out  1  1-cycle pulse: no tick by PERIOD+TOL
//  locked     out  1  level: LOCK_N consecutive good intervals, no error since
//  err_count  out  8  early+late error total, saturates at 255
//  last_iv    out  CW last measured interval (early or good), for debug
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE; all outputs 0; interval counter 0.
//   tick_in previous-sample register = 0, good-run counter = 0.
//  Edge detect: tick_prev<=tick_in every cycle; ev = tick_in & ~tick_prev.
//   Level held high counts as one event.
//  States:
//   IDLE: en=0. Counter held at 0; locked=0; err_count held.
//    en=1 -> SYNC next cycle.
//   SYNC: wait for first ev.
//    On ev: counter<=1, run<=0 -> RUN. No flag pulses.
//   RUN: counter increments by 1 per cycle without ev.
//    On ev with I=counter value in that cycle:
//     I<PERIOD-TOL: early_err, run<=0, locked<=0, counter<=1 (tick becomes new reference).
//     in window: good; run<=run+1 (saturating); locked<=1 when run+1>=LOCK_N; counter<=1.
//     Either case: last_iv<=I.
//    No ev and counter==PERIOD+TOL:
//     late_err, run<=0, locked<=0, counter<=0 -> SYNC (resynchronise on next tick).
//  Latency: all flags, last_iv and err_count are registered.
//   They update 1 cycle after the ev cycle (or after the timeout cycle).
//  Pulses: good, early_err and late_err are mutually exclusive, each high exactly 1 cycle.
//  err_count: +1 per early_err/late_err; holds at 255; cleared only by rst.
//  Boundaries:
//   I==PERIOD-TOL or I==PERIOD+TOL is good.
//   Timeout fires at the PERIOD+TOL cycle only if ev is absent in that same cycle.
//  en deasserted mid-RUN: next cycle IDLE, locked=0, no flag.
//   Re-enable starts again from SYNC.
//  rst mid-operation overrides en and tick_in.
// TESTING
//  T1: rst 3 cycles, en=1, ticks every 250 cycles x6
//      -> no flag on 1st tick; good on ticks 2..6; locked high 1 cycle after 5th tick; err_count=0.
//  T2: locked, next tick after 247 cycles -> early_err, locked=0, last_iv=247, err_count=1.
//      Following 250-cycle ticks need 4 goods to relock.
//  T3: locked, tick withheld -> late_err 1 cycle after counter hits 252, state SYNC.
//      Next tick gives no flag; the one after gives good.
//  T4: intervals of 248 and 252 -> good both; 253 -> late_err at 252, and the tick at 253 only resyncs.
//  T5: tick_in held high 5 cycles, period 250 -> one event per period, good each period.
//  T6: en dropped mid-RUN, and separately rst asserted mid-RUN
//      -> locked=0 next cycle, no pulses; rst also clears err_count.
//      Force >255 errors -> err_count stays 255.

Source files
------------

// File: rtl/lfsr_tick_monitor.sv
// Receive-side checker for periodic single-cycle timer ticks: measures tick-to-tick
// intervals, flags good/early/late, tracks lock and a saturating error count.
module lfsr_tick_monitor #(
  parameter int PERIOD = 250,
  parameter int TOL    = 2,
  parameter int LOCK_N = 4,
  parameter int CW     = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          tick_in,
  output logic          good,
  output logic          early_err,
  output logic          late_err,
  output logic          locked,
  output logic [7:0]    err_count,
  output logic [CW-1:0] last_iv
);

  // state | meaning
  // IDLE  | monitor disabled, counter cleared
  // SYNC  | waiting for the first tick to use as reference
  // RUN   | measuring the interval since the reference tick
  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  localparam logic [CW-1:0] IV_LO = CW'(PERIOD - TOL);
  localparam logic [CW-1:0] IV_HI = CW'(PERIOD + TOL);

  state_t        state;
  logic          tick_prev;
  logic [CW-1:0] cnt;
  logic [3:0]    run;
  logic [3:0]    run_inc;
  logic [7:0]    err_inc;
  logic          ev;

  assign ev      = tick_in & ~tick_prev;
  assign run_inc = (run == 4'hF) ? run : run + 4'd1;
  assign err_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_prev <= 1'b0;
      cnt       <= '0;
      run       <= '0;
      good      <= 1'b0;
      early_err <= 1'b0;
      late_err  <= 1'b0;
      locked    <= 1'b0;
      err_count <= '0;
      last_iv   <= '0;
    end else begin
      tick_prev <= tick_in;
      good      <= 1'b0;
      early_err <= 1'b0;
      late_err  <= 1'b0;
      if (!en) begin
        state  <= IDLE;
        cnt    <= '0;
        run    <= '0;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (ev) begin
              cnt   <= CW'(1);
              run   <= '0;
              state <= RUN;
            end
          end
          RUN: begin
            if (ev) begin
              // the tick always becomes the new reference, early or not
              last_iv <= cnt;
              cnt     <= CW'(1);
              if (cnt < IV_LO) begin
                early_err <= 1'b1;
                run       <= '0;
                locked    <= 1'b0;
                err_count <= err_inc;
              end else begin
                good <= 1'b1;
                run  <= run_inc;
                if (run_inc >= 4'(LOCK_N)) locked <= 1'b1;
              end
            end else if (cnt == IV_HI) begin
              late_err  <= 1'b1;
              run       <= '0;
              locked    <= 1'b0;
              err_count <= err_inc;
              cnt       <= '0;
              state     <= SYNC;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
